// File: rtl/div_issue.sv
`timescale 1ns/1ps
`default_nettype none
// div_issue: operand-issue / result-capture stage around the combinational divider `div`.
// Optional DIV_ISSUE_SKID_EN adds a one-entry input buffer so a new pair can be taken during HOLD.
module div_issue #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_dbz
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

`ifdef DIV_ISSUE_SKID_EN
  localparam logic SKID = 1'b1;
  logic             buf_valid;
  logic [WIDTH-1:0] buf_a;
  logic [WIDTH-1:0] buf_b;
`else
  localparam logic SKID = 1'b0;
`endif

  state_t           state;
  logic [3:0]       cnt;
  logic             iss_go;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;

  // Selects which operand pair (if any) is launched this cycle.
  always_comb begin
    iss_go = 1'b0;
    iss_a  = in_a;
    iss_b  = in_b;
    case (state)
      IDLE: iss_go = in_valid && in_ready;
      HOLD: begin
`ifdef DIV_ISSUE_SKID_EN
        if (out_ready) begin
          if (buf_valid) begin
            iss_go = 1'b1;
            iss_a  = buf_a;
            iss_b  = buf_b;
          end else begin
            iss_go = in_valid && in_ready;
          end
        end
`endif
      end
      default: iss_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      div_a         <= '0;
      div_b         <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
`ifdef DIV_ISSUE_SKID_EN
      buf_valid     <= 1'b0;
      buf_a         <= '0;
      buf_b         <= '0;
`endif
    end else if (iss_go) begin
      div_a <= iss_a;
      div_b <= iss_b;
      if (iss_b != '0) begin
        state     <= ISSUE;
        cnt       <= CNT_INIT;
        in_ready  <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        // Zero divisor: synthesize the result here so the divider output is never used.
        state         <= HOLD;
        out_quotient  <= '1;
        out_remainder <= iss_a;
        out_dbz       <= 1'b1;
        out_valid     <= 1'b1;
        in_ready      <= SKID;
      end
`ifdef DIV_ISSUE_SKID_EN
      buf_valid <= 1'b0;
`endif
    end else begin
      case (state)
        ISSUE: begin
          if (cnt == 4'd0) begin
            state         <= HOLD;
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
            out_dbz       <= 1'b0;
            out_valid     <= 1'b1;
            in_ready      <= SKID;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
`ifdef DIV_ISSUE_SKID_EN
          else if (in_valid && in_ready) begin
            buf_a     <= in_a;
            buf_b     <= in_b;
            buf_valid <= 1'b1;
            in_ready  <= 1'b0;
          end
`endif
        end
        IDLE: state <= IDLE;
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_issue.sv
`timescale 1ns/1ps
`default_nettype none
// tb_div_issue: directed vectors for div_issue (default and SETTLE_CYCLES=3 instances).
module tb_div_issue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic       in_valid0, in_ready0, out_valid0, out_ready0, out_dbz0;
  logic [3:0] in_a0, in_b0, div_a0, div_b0, dq0, dr0, out_q0, out_r0;
  // Instance 3: SETTLE_CYCLES = 3
  logic       in_valid3, in_ready3, out_valid3, out_ready3, out_dbz3;
  logic [3:0] in_a3, in_b3, div_a3, div_b3, dq3, dr3, out_q3, out_r3;

  // Divider models; a zero divisor yields distinctive garbage that must never reach the outputs.
  assign dq0 = (div_b0 != 4'd0) ? div_a0 / div_b0 : 4'hA;
  assign dr0 = (div_b0 != 4'd0) ? div_a0 % div_b0 : 4'h5;
  assign dq3 = (div_b3 != 4'd0) ? div_a3 / div_b3 : 4'hA;
  assign dr3 = (div_b3 != 4'd0) ? div_a3 % div_b3 : 4'h5;

  div_issue #(.WIDTH(4), .SETTLE_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .div_a(div_a0), .div_b(div_b0), .div_quotient(dq0), .div_remainder(dr0),
    .out_valid(out_valid0), .out_ready(out_ready0),
    .out_quotient(out_q0), .out_remainder(out_r0), .out_dbz(out_dbz0)
  );

  div_issue #(.WIDTH(4), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_a(in_a3), .in_b(in_b3),
    .div_a(div_a3), .div_b(div_b3), .div_quotient(dq3), .div_remainder(dr3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_quotient(out_q3), .out_remainder(out_r3), .out_dbz(out_dbz3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a pair to instance 0 at a negedge; returns at the first negedge after the accepting edge.
  task automatic offer0(input logic [3:0] a, input logic [3:0] b);
    in_a0 = a; in_b0 = b; in_valid0 = 1'b1;
    chk("in_ready_before_accept", in_ready0, 1'b1);
    @(negedge clk);
    in_valid0 = 1'b0;
  endtask

  // Latency counted with the cycle right after the accepting edge as 1.
  task automatic wait_valid0(output int lat);
    lat = 1;
    while (!out_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int  lat;
  logic seen;

  initial begin
    rst = 1'b1;
    in_valid0 = 0; in_a0 = 0; in_b0 = 0; out_ready0 = 0;
    in_valid3 = 0; in_a3 = 0; in_b3 = 0; out_ready3 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 1'b1);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_div_a", div_a0, 4'd0);
    chk("rst_div_b", div_b0, 4'd0);
    chk("rst_q", out_q0, 4'd0);
    chk("rst_r", out_r0, 4'd0);
    chk("rst_dbz", out_dbz0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 9 / 2
    out_ready0 = 1'b1;
    offer0(4'd9, 4'd2);
    chk("t1_div_a", div_a0, 4'd9);
    chk("t1_div_b", div_b0, 4'd2);
    chk("t1_in_ready_issue", in_ready0, 1'b0);
    wait_valid0(lat);
    chk("t1_latency", lat, 2);
    chk("t1_q", out_q0, 4'd4);
    chk("t1_r", out_r0, 4'd1);
    chk("t1_dbz", out_dbz0, 1'b0);
    @(negedge clk);
    chk("t1_valid_drop", out_valid0, 1'b0);

    // 9 / 0
    offer0(4'd9, 4'd0);
    wait_valid0(lat);
    chk("t2_latency", lat, 1);
    chk("t2_q", out_q0, 4'hF);
    chk("t2_r", out_r0, 4'd9);
    chk("t2_dbz", out_dbz0, 1'b1);
    @(negedge clk);
    chk("t2_valid_drop", out_valid0, 1'b0);

    // 7 / 9 with downstream stalled
    out_ready0 = 1'b0;
    offer0(4'd7, 4'd9);
    wait_valid0(lat);
    chk("t3_latency", lat, 2);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", out_valid0, 1'b1);
      chk("t3_hold_q", out_q0, 4'd0);
      chk("t3_hold_r", out_r0, 4'd7);
`ifndef DIV_ISSUE_SKID_EN
      chk("t3_hold_in_ready", in_ready0, 1'b0);
`endif
      @(negedge clk);
    end
    out_ready0 = 1'b1;
    @(negedge clk);
    out_ready0 = 1'b0;
    chk("t3_handshake", out_valid0, 1'b0);
    @(negedge clk);
    chk("t3_single_handshake", out_valid0, 1'b0);

    // SETTLE_CYCLES=3: 15 / 15
    out_ready3 = 1'b1;
    in_a3 = 4'd15; in_b3 = 4'd15; in_valid3 = 1'b1;
    chk("t4_in_ready", in_ready3, 1'b1);
    @(negedge clk);
    in_valid3 = 1'b0;
    lat = 1;
    while (!out_valid3 && lat < 20) begin
      chk("t4_div_a_stable", div_a3, 4'd15);
      chk("t4_div_b_stable", div_b3, 4'd15);
      @(negedge clk);
      lat++;
    end
    chk("t4_latency", lat, 4);
    chk("t4_q", out_q3, 4'd1);
    chk("t4_r", out_r3, 4'd0);
    chk("t4_dbz", out_dbz3, 1'b0);

    // Reset while in ISSUE
    out_ready0 = 1'b1;
    offer0(4'd9, 4'd2);
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid0, 1'b0);
    chk("t5_rst_in_ready", in_ready0, 1'b1);
    chk("t5_rst_div_a", div_a0, 4'd0);
    chk("t5_rst_div_b", div_b0, 4'd0);
    chk("t5_rst_q", out_q0, 4'd0);
    chk("t5_rst_r", out_r0, 4'd0);
    chk("t5_rst_dbz", out_dbz0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | out_valid0;
    end
    chk("t5_no_valid_after_rst", seen, 1'b0);
    offer0(4'd6, 4'd3);
    wait_valid0(lat);
    chk("t5_latency", lat, 2);
    chk("t5_q", out_q0, 4'd2);
    chk("t5_r", out_r0, 4'd0);
    @(negedge clk);

`ifdef DIV_ISSUE_SKID_EN
    // Back-to-back: second pair taken during HOLD, no IDLE gap between handshakes
    out_ready0 = 1'b1;
    offer0(4'd8, 4'd2);
    in_a0 = 4'd5; in_b0 = 4'd0; in_valid0 = 1'b1;
    @(negedge clk);
    chk("t6_first_valid", out_valid0, 1'b1);
    chk("t6_first_q", out_q0, 4'd4);
    chk("t6_first_r", out_r0, 4'd0);
    chk("t6_in_ready_hold", in_ready0, 1'b1);
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("t6_second_valid", out_valid0, 1'b1);
    chk("t6_second_q", out_q0, 4'hF);
    chk("t6_second_r", out_r0, 4'd5);
    chk("t6_second_dbz", out_dbz0, 1'b1);
    @(negedge clk);
    chk("t6_valid_drop", out_valid0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/div_issue.md
Name: div_issue

Overview:
- Sequential operand-issue and result-capture stage wrapped around the combinational 4-bit divider `div`.
- Accepts operand pairs over a valid/ready handshake and drives them onto the divider's a/b inputs. Waits a fixed settle time, then registers quotient/remainder.
- Presents the result downstream over a second valid/ready handshake.
- Handles divide-by-zero locally, so the divider's undefined b=0 output never reaches the consumer.

Parameters:
- WIDTH, 4, operand/result width; must match the `div` instance.
- SETTLE_CYCLES, 1, cycles operands are held on div_a/div_b before capture (range 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream operand pair valid.
- in_ready  output  1  stage can accept an operand pair.
- in_a  input  WIDTH  dividend.
- in_b  input  WIDTH  divisor.
- div_a  output  WIDTH  dividend to divider (registered).
- div_b  output  WIDTH  divisor to divider (registered).
- div_quotient  input  WIDTH  quotient from divider.
- div_remainder  input  WIDTH  remainder from divider.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_quotient  output  WIDTH  registered quotient.
- out_remainder  output  WIDTH  registered remainder.
- out_dbz  output  1  result came from a divide-by-zero.

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready=1; out_valid=0; div_a, div_b, out_quotient, out_remainder = 0; out_dbz=0; settle counter=0.
- FSM states are IDLE, ISSUE and HOLD.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_a→div_a and in_b→div_b.
    - If in_b!=0: load counter=SETTLE_CYCLES-1 and go to ISSUE.
    - If in_b==0: load out_quotient={WIDTH{1'b1}}, out_remainder=in_a, out_dbz=1, and go to HOLD. The divider is bypassed.
  - ISSUE: in_ready=0; div_a/div_b held stable.
    - If counter==0: capture div_quotient→out_quotient and div_remainder→out_remainder, set out_dbz=0, go to HOLD.
    - Otherwise decrement the counter.
  - HOLD: out_valid=1; outputs held stable while out_ready=0.
    - On out_ready: go to IDLE; out_valid drops the next cycle.
    - out_quotient/out_remainder retain their value after the handshake; they are only meaningful while out_valid=1.
- Latency, measured from the accepting edge:
  - Normal operation: out_valid rises SETTLE_CYCLES+1 edges later (2 for the default).
  - Divide-by-zero: out_valid rises 1 edge later.
- Throughput without the optional feature: one operation per SETTLE_CYCLES+2 cycles minimum, because IDLE costs one cycle after each HOLD.
- in_valid is ignored outside IDLE. Upstream must hold in_a/in_b stable until in_ready is seen high.
- out_valid never deasserts without an out_ready handshake.
- No arithmetic in this block beyond the counter. Widths pass straight through.
- Reset mid-operation (ISSUE or HOLD) aborts immediately. The in-flight result is discarded and no out_valid is produced.

Optional Feature:
- Macro: DIV_ISSUE_SKID_EN.
- With the macro defined:
  - A one-entry input buffer lets in_ready=1 in HOLD while the buffer is empty.
  - An operand pair accepted in HOLD is stored in the buffer.
  - On the out_ready handshake, the buffered pair is issued directly (to ISSUE, or to HOLD if b==0), skipping IDLE.
  - Back-to-back throughput becomes one operation per SETTLE_CYCLES+1 cycles.
  - Reset clears the buffer.
- Without the macro: no buffer; in_ready=1 only in IDLE.

Test Plan:
- Reset then a=4'b1001, b=4'b0010 with out_ready=1 → out_valid 2 cycles after accept; out_quotient=4'b0100, out_remainder=4'b0001, out_dbz=0.
- a=4'b1001, b=4'b0000 → out_valid 1 cycle after accept; out_quotient=4'b1111, out_remainder=4'b1001, out_dbz=1; div_b=0 never captured.
- a=4'b0111, b=4'b1001, out_ready held 0 for 5 cycles → out_valid stays 1; out_quotient=0, out_remainder=4'b0111 stable; in_ready=0 throughout (non-skid build); one handshake when out_ready rises.
- SETTLE_CYCLES=3, a=4'b1111, b=4'b1111 → div_a/div_b stable 3 cycles; out_quotient=4'b0001, out_remainder=0 at latency 4.
- Assert rst in ISSUE → all outputs 0 and in_ready=1 in the same cycle; no out_valid afterwards; next operation (a=6, b=3 → q=2, r=0) completes normally.
- DIV_ISSUE_SKID_EN: offer a=8, b=2 then a=5, b=0 back-to-back with out_ready=1 → second accepted during HOLD; results (q=4, r=0) then (q=15, r=5, dbz=1) on consecutive handshakes with no IDLE gap.
